next_pc_predictor: RTL and testbench

//   Next-PC generator feeding the PC register (N_PC / PC_En) of the 5-stage MIPS pipeline.

---
 rtl/next_pc_predictor_if.sv | 31 +++
 rtl/next_pc_predictor.sv | 114 +++++++++++
 tb/tb_next_pc_predictor.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/next_pc_predictor_if.sv
// Fetch-side bundle between the pipeline and the next-PC predictor: lookup inputs,
// EX resolution feedback, and the next-PC / flush / statistics outputs.
interface next_pc_predictor_if;
  logic        stall;
  logic [31:0] current_pc;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_is_branch;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic [31:0] n_pc;
  logic        pc_en;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        flush;
  logic [15:0] mispredict_cnt;

  modport master (
    output stall, current_pc, ex_valid, ex_pc, ex_is_branch, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    input  n_pc, pc_en, pred_taken, pred_target, flush, mispredict_cnt
  );

  modport slave (
    input  stall, current_pc, ex_valid, ex_pc, ex_is_branch, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    output n_pc, pc_en, pred_taken, pred_target, flush, mispredict_cnt
  );
endinterface

// File: rtl/next_pc_predictor.sv
// Next-PC generator: direct-mapped BTB with 2-bit saturating counters, zero-latency lookup,
// and same-cycle redirect/flush when EX resolves a mispredicted control transfer.
module next_pc_predictor #(
  parameter int unsigned ENTRIES  = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input logic                 clk,
  input logic                 reset,
  next_pc_predictor_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 32 - IDX_W - 2;

  logic             valid_q  [ENTRIES];
  logic             valid_d  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [31:0]      target_d [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic [1:0]       ctr_d    [ENTRIES];
  logic [15:0]      cnt_q, cnt_d;

  logic [IDX_W-1:0] lk_idx, ex_idx;
  logic [TAG_W-1:0] lk_tag, ex_tag;
  logic             lk_hit, ex_hit, lk_taken, redir;

  assign lk_idx = bus.current_pc[IDX_W+1:2];
  assign lk_tag = bus.current_pc[31:IDX_W+2];
  assign ex_idx = bus.ex_pc[IDX_W+1:2];
  assign ex_tag = bus.ex_pc[31:IDX_W+2];

  assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign ex_hit   = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign lk_taken = lk_hit && ctr_q[lk_idx][1];

  // Wrong direction, wrong target on a taken branch, or a BTB alias hit on a non-branch.
  assign redir = bus.ex_valid &&
                 ((bus.ex_is_branch && (bus.ex_taken != bus.ex_pred_taken)) ||
                  (bus.ex_is_branch && bus.ex_taken && bus.ex_pred_taken &&
                   (bus.ex_target != bus.ex_pred_target)) ||
                  (!bus.ex_is_branch && bus.ex_pred_taken));

  always_comb begin
    bus.pred_target = target_q[lk_idx];
    if (reset) begin
      bus.n_pc       = RESET_PC;
      bus.pc_en      = 1'b1;
      bus.flush      = 1'b0;
      bus.pred_taken = 1'b0;
    end else begin
      bus.pred_taken = lk_taken;
      bus.flush      = redir;
      bus.pc_en      = !bus.stall || redir;
      if (redir) begin
        bus.n_pc = (bus.ex_taken && bus.ex_is_branch) ? bus.ex_target : bus.ex_pc + 32'd4;
      end else if (lk_taken) begin
        bus.n_pc = target_q[lk_idx];
      end else begin
        bus.n_pc = bus.current_pc + 32'd4;
      end
    end
  end

  assign bus.mispredict_cnt = cnt_q;

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (bus.ex_valid) begin
      if (bus.ex_is_branch) begin
        if (ex_hit) begin
          if (bus.ex_taken) begin
            if (ctr_q[ex_idx] != 2'b11) ctr_d[ex_idx] = ctr_q[ex_idx] + 2'd1;
            target_d[ex_idx] = bus.ex_target;
          end else if (ctr_q[ex_idx] != 2'b00) begin
            ctr_d[ex_idx] = ctr_q[ex_idx] - 2'd1;
          end
        end else begin
          valid_d[ex_idx]  = 1'b1;
          tag_d[ex_idx]    = ex_tag;
          target_d[ex_idx] = bus.ex_target;
          ctr_d[ex_idx]    = bus.ex_taken ? 2'b10 : 2'b01;
        end
      end else if (bus.ex_pred_taken) begin
        valid_d[ex_idx] = 1'b0;
      end
    end
  end

  assign cnt_d = cnt_q + {15'd0, redir};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
      cnt_q <= '0;
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_next_pc_predictor.sv
// Self-checking bench for next_pc_predictor: directed scenarios plus randomized traffic
// compared against a table-level behavioural model.
module tb_next_pc_predictor;

  localparam int unsigned N        = 16;
  localparam int unsigned IB       = $clog2(N);
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  next_pc_predictor_if bus ();

  next_pc_predictor #(.ENTRIES(N), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: per-index entry holding the full allocating PC, its target and a 0..3 counter.
  bit          m_valid [N];
  logic [31:0] m_pc    [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];
  int          m_cnt;

  function automatic int ix(logic [31:0] pc);
    return int'((pc / 4) % N);
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    return m_valid[ix(pc)] && ((m_pc[ix(pc)] >> (IB + 2)) == (pc >> (IB + 2)));
  endfunction

  function automatic bit m_pred(logic [31:0] pc);
    return m_hit(pc) && (m_ctr[ix(pc)] >= 2);
  endfunction

  function automatic bit m_redir();
    if (!bus.ex_valid) return 0;
    if (bus.ex_is_branch) begin
      if (bus.ex_taken != bus.ex_pred_taken) return 1;
      return bus.ex_taken && (bus.ex_target != bus.ex_pred_target);
    end
    return bus.ex_pred_taken;
  endfunction

  function automatic logic [31:0] m_npc();
    if (reset) return RESET_PC;
    if (m_redir()) return (bus.ex_is_branch && bus.ex_taken) ? bus.ex_target : bus.ex_pc + 4;
    if (m_pred(bus.current_pc)) return m_tgt[ix(bus.current_pc)];
    return bus.current_pc + 4;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < int'(N); i++) begin
      m_valid[i] = 0;
      m_ctr[i]   = 1;
      m_pc[i]    = '0;
      m_tgt[i]   = '0;
    end
    m_cnt = 0;
  endfunction

  function automatic void m_update();
    int k;
    if (reset) begin
      m_reset();
      return;
    end
    if (m_redir()) m_cnt = (m_cnt + 1) % 65536;
    if (!bus.ex_valid) return;
    k = ix(bus.ex_pc);
    if (bus.ex_is_branch) begin
      if (m_hit(bus.ex_pc)) begin
        if (bus.ex_taken) begin
          m_ctr[k] = (m_ctr[k] == 3) ? 3 : m_ctr[k] + 1;
          m_tgt[k] = bus.ex_target;
        end else begin
          m_ctr[k] = (m_ctr[k] == 0) ? 0 : m_ctr[k] - 1;
        end
      end else begin
        m_valid[k] = 1;
        m_pc[k]    = bus.ex_pc;
        m_tgt[k]   = bus.ex_target;
        m_ctr[k]   = bus.ex_taken ? 2 : 1;
      end
    end else if (bus.ex_pred_taken) begin
      m_valid[k] = 0;
    end
  endfunction

  // Advance one clock: commit the model, take the edge, settle 1 time unit past it.
  task automatic step();
    m_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(logic [31:0] pc);
    bus.stall      = 1'b0;
    bus.current_pc = pc;
    bus.ex_valid   = 1'b0;
    bus.ex_is_branch = 1'b0;
    bus.ex_taken   = 1'b0;
    bus.ex_pred_taken = 1'b0;
  endtask

  task automatic ex(logic [31:0] pc, bit br, bit tk, logic [31:0] tgt, bit pt,
                    logic [31:0] ptgt);
    bus.ex_valid       = 1'b1;
    bus.ex_pc          = pc;
    bus.ex_is_branch   = br;
    bus.ex_taken       = tk;
    bus.ex_target      = tgt;
    bus.ex_pred_taken  = pt;
    bus.ex_pred_target = ptgt;
  endtask

  task automatic test_reset();
    m_reset();
    reset = 1'b1;
    idle(32'h0000_5550);
    ex(32'h0000_3010, 1, 1, 32'h0000_3040, 0, 0);
    #1;
    checks++;
    if (bus.n_pc !== RESET_PC || bus.pc_en !== 1'b1 || bus.flush !== 1'b0 ||
        bus.pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: n_pc=%h pc_en=%b flush=%b pt=%b, want %h 1 0 0",
               bus.n_pc, bus.pc_en, bus.flush, bus.pred_taken, RESET_PC);
    end
    step();
    step();
    reset = 1'b0;
    idle(32'h0000_3000);
    #1;
    checks++;
    if (bus.n_pc !== 32'h0000_3004 || bus.pred_taken !== 1'b0 || bus.mispredict_cnt !== 16'd0)
    begin
      failures++;
      $display("FAIL reset_first_fetch: n_pc=%h pt=%b cnt=%0d, want 00003004 0 0",
               bus.n_pc, bus.pred_taken, bus.mispredict_cnt);
    end
  endtask

  task automatic test_cold_branch();
    idle(32'h0000_3000);
    ex(32'h0000_3010, 1, 1, 32'h0000_3040, 0, 0);
    #1;
    checks++;
    if (bus.flush !== 1'b1 || bus.n_pc !== 32'h0000_3040 || bus.pc_en !== 1'b1) begin
      failures++;
      $display("FAIL cold_redirect: flush=%b n_pc=%h pc_en=%b, want 1 00003040 1",
               bus.flush, bus.n_pc, bus.pc_en);
    end
    step();
    idle(32'h0000_3010);
    #1;
    checks++;
    if (bus.mispredict_cnt !== 16'd1) begin
      failures++;
      $display("FAIL cold_count: cnt=%0d want 1", bus.mispredict_cnt);
    end
    checks++;
    if (bus.pred_taken !== 1'b1 || bus.pred_target !== 32'h0000_3040 ||
        bus.n_pc !== 32'h0000_3040) begin
      failures++;
      $display("FAIL cold_lookup: pt=%b ptgt=%h n_pc=%h, want 1 00003040 00003040",
               bus.pred_taken, bus.pred_target, bus.n_pc);
    end
    step();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) begin
      idle(32'h0000_3000);
      ex(32'h0000_3010, 1, 1, 32'h0000_3040, 1, 32'h0000_3040);
      #1;
      checks++;
      if (bus.flush !== 1'b0) begin
        failures++;
        $display("FAIL sat_no_redirect[%0d]: flush=%b want 0", i, bus.flush);
      end
      step();
    end
    idle(32'h0000_3000);
    ex(32'h0000_3010, 1, 0, 32'h0000_3040, 1, 32'h0000_3040);
    step();
    idle(32'h0000_3010);
    #1;
    checks++;
    if (bus.pred_taken !== 1'b1) begin
      failures++;
      $display("FAIL sat_one_not_taken: pt=%b want 1", bus.pred_taken);
    end
    ex(32'h0000_3010, 1, 0, 32'h0000_3040, 1, 32'h0000_3040);
    step();
    idle(32'h0000_3010);
    #1;
    checks++;
    if (bus.pred_taken !== 1'b0 || bus.n_pc !== 32'h0000_3014 ||
        int'(bus.mispredict_cnt) != m_cnt) begin
      failures++;
      $display("FAIL sat_two_not_taken: pt=%b n_pc=%h cnt=%0d, want 0 00003014 %0d",
               bus.pred_taken, bus.n_pc, bus.mispredict_cnt, m_cnt);
    end
  endtask

  task automatic test_stall();
    idle(32'h0000_3100);
    bus.stall = 1'b1;
    #1;
    checks++;
    if (bus.pc_en !== 1'b0 || bus.flush !== 1'b0) begin
      failures++;
      $display("FAIL stall_hold: pc_en=%b flush=%b want 0 0", bus.pc_en, bus.flush);
    end
    step();
    ex(32'h0000_3020, 1, 0, 32'h0000_3080, 1, 32'h0000_3080);
    #1;
    checks++;
    if (bus.pc_en !== 1'b1 || bus.n_pc !== 32'h0000_3024 || bus.flush !== 1'b1) begin
      failures++;
      $display("FAIL stall_redirect: pc_en=%b n_pc=%h flush=%b, want 1 00003024 1",
               bus.pc_en, bus.n_pc, bus.flush);
    end
    step();
  endtask

  task automatic test_alias();
    idle(32'h0000_3000);
    ex(32'h0000_3010, 1, 1, 32'h0000_3040, m_pred(32'h0000_3010), 32'h0000_3040);
    step();
    idle(32'h0000_3010);
    #1;
    checks++;
    if (bus.pred_taken !== 1'b1) begin
      failures++;
      $display("FAIL alias_setup: pt=%b want 1", bus.pred_taken);
    end
    ex(32'h0000_3050, 0, 0, 32'h0, 1, 32'h0000_3040);
    #1;
    checks++;
    if (bus.flush !== 1'b1 || bus.n_pc !== 32'h0000_3054) begin
      failures++;
      $display("FAIL alias_redirect: flush=%b n_pc=%h, want 1 00003054", bus.flush, bus.n_pc);
    end
    step();
    idle(32'h0000_3010);
    #1;
    checks++;
    if (bus.pred_taken !== 1'b0 || bus.n_pc !== 32'h0000_3014) begin
      failures++;
      $display("FAIL alias_invalidated: pt=%b n_pc=%h, want 0 00003014",
               bus.pred_taken, bus.n_pc);
    end
  endtask

  task automatic test_same_cycle();
    idle(32'h0000_3010);
    ex(32'h0000_3010, 1, 1, 32'h0000_3040, 0, 0);
    #1;
    checks++;
    if (bus.pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL same_cycle_old: pt=%b want 0", bus.pred_taken);
    end
    step();
    idle(32'h0000_3010);
    #1;
    checks++;
    if (bus.pred_taken !== 1'b1 || bus.pred_target !== 32'h0000_3040) begin
      failures++;
      $display("FAIL same_cycle_new: pt=%b ptgt=%h, want 1 00003040",
               bus.pred_taken, bus.pred_target);
    end
  endtask

  task automatic test_reset_mid_update();
    idle(32'h0000_3018);
    ex(32'h0000_3018, 1, 1, 32'h0000_3060, 0, 0);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.flush !== 1'b0 || bus.n_pc !== RESET_PC) begin
      failures++;
      $display("FAIL reset_mid_outputs: flush=%b n_pc=%h, want 0 %h", bus.flush, bus.n_pc,
               RESET_PC);
    end
    step();
    reset = 1'b0;
    idle(32'h0000_3018);
    #1;
    checks++;
    if (bus.pred_taken !== 1'b0 || bus.mispredict_cnt !== 16'd0 ||
        bus.n_pc !== 32'h0000_301c) begin
      failures++;
      $display("FAIL reset_mid_discard: pt=%b cnt=%0d n_pc=%h, want 0 0 0000301c",
               bus.pred_taken, bus.mispredict_cnt, bus.n_pc);
    end
  endtask

  function automatic logic [31:0] rnd_pc();
    return 32'h0000_3000 + 32'(4 * $urandom_range(0, 31));
  endfunction

  task automatic test_random();
    logic [31:0] epc;
    for (int i = 0; i < 400; i++) begin
      reset          = ($urandom_range(0, 63) == 0);
      bus.stall      = ($urandom_range(0, 3) == 0);
      bus.current_pc = rnd_pc();
      epc            = rnd_pc();
      if ($urandom_range(0, 2) != 0) begin
        if ($urandom_range(0, 3) != 0)
          ex(epc, $urandom_range(0, 4) != 0, 1'($urandom), rnd_pc(), m_pred(epc),
             m_tgt[ix(epc)]);
        else
          ex(epc, 1'($urandom), 1'($urandom), rnd_pc(), 1'($urandom), rnd_pc());
      end else begin
        bus.ex_valid = 1'b0;
      end
      #1;
      checks++;
      if (bus.n_pc !== m_npc() ||
          bus.pc_en !== (reset || !bus.stall || m_redir()) ||
          bus.flush !== (!reset && m_redir()) ||
          bus.pred_taken !== (!reset && m_pred(bus.current_pc)) ||
          int'(bus.mispredict_cnt) != m_cnt ||
          (bus.pred_taken === 1'b1 && bus.pred_target !== m_tgt[ix(bus.current_pc)])) begin
        failures++;
        $display("FAIL random[%0d]: n_pc=%h pc_en=%b flush=%b pt=%b ptgt=%h cnt=%0d, want %h %b %b %b %h %0d",
                 i, bus.n_pc, bus.pc_en, bus.flush, bus.pred_taken, bus.pred_target,
                 bus.mispredict_cnt, m_npc(), reset || !bus.stall || m_redir(),
                 !reset && m_redir(), !reset && m_pred(bus.current_pc),
                 m_tgt[ix(bus.current_pc)], m_cnt);
      end
      step();
    end
    reset = 1'b0;
  endtask

  initial begin
    bus.ex_pc          = '0;
    bus.ex_target      = '0;
    bus.ex_pred_target = '0;
    test_reset();
    test_cold_branch();
    test_saturation();
    test_stall();
    test_alias();
    test_same_cycle();
    test_reset_mid_update();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
